servo_axil_slave: RTL
=====================

SERVO_AXIL_SLAVE -- requirements
Module: servo_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width covering 4 registers.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 ACLK  in  1  clock; every register samples on the rising edge.
REQ-005 ARESETN  in  1  asynchronous active-low reset.
REQ-006 AWADDR  in  4  write address; AWPROT in 3, ignored; AWVALID in 1; AWREADY out 1.
REQ-007 WDATA  in  32; WSTRB in 4; WVALID in 1; WREADY out 1.
REQ-008 BRESP  out  2; BVALID out 1; BREADY in 1.
REQ-009 ARADDR  in  4; ARPROT in 3, ignored; ARVALID in 1; ARREADY out 1.
REQ-010 RDATA  out  32; RRESP out 2; RVALID out 1; RREADY in 1.
REQ-011 servo_pwm  out  1  servo pulse output.

Function
REQ-012 Register map, decoded from addr[3:2] with addr[1:0] ignored: 0x0 CTRL (bit0 enable, bits 31:1 read back as written); 0x4 PERIOD (PWM period in ACLK cycles); 0x8 PULSE (high time in ACLK cycles); 0xC SCRATCH. All registers SHALL be read/write.
REQ-013 Write FSM states: W_IDLE, W_ACK, W_RESP.
- In W_IDLE, when AWVALID and WVALID are both high, go to W_ACK.
- AWVALID alone or WVALID alone SHALL NOT be accepted.
REQ-014 W_ACK: AWREADY and WREADY high together for exactly one cycle; the register commits on that edge, byte lane n written only when WSTRB[n]=1; go to W_RESP.
REQ-015 W_RESP: BVALID high with BRESP=2'b00 until the cycle BREADY is sampled high, then W_IDLE; no new write accepted meanwhile.
REQ-016 Read FSM states: R_IDLE, R_ACK, R_DATA.
- R_IDLE -> R_ACK on ARVALID.
- R_ACK: ARREADY high one cycle; RDATA captured on that edge; go to R_DATA.
- R_DATA: RVALID high, RRESP=2'b00, RDATA stable, until RREADY sampled high; then R_IDLE.
REQ-017 Read and write FSMs SHALL be independent; at most one outstanding transaction each.
REQ-018 Write and read capture on the same edge at the same address: the read SHALL return the pre-write value.
REQ-019 Write latency: the minimum from AWVALID&WVALID to BVALID is 2 cycles. Read latency: the minimum from ARVALID to RVALID is 2 cycles.
REQ-020 PWM counter runs 0..PERIOD_act-1 and wraps to 0.
- servo_pwm = enable && (cnt < PULSE_act), registered, so it lags the compare by 1 cycle.
REQ-021 PERIOD_act and PULSE_act are shadow copies loaded from PERIOD/PULSE when cnt wraps, or when enable is 0.
- Mid-period writes SHALL take effect only at the next period boundary.
REQ-022 Boundary cases:
- PERIOD=0 or enable=0: cnt held at 0, servo_pwm=0.
- PULSE=0: servo_pwm stays 0.
- PULSE>=PERIOD: servo_pwm constantly 1 while enabled.
REQ-023 Clearing enable SHALL force servo_pwm=0 within 1 cycle and reset cnt to 0.

Reset
REQ-024 While ARESETN=0, the following SHALL be 0: all registers, shadows, cnt, AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA, BRESP, RRESP and servo_pwm. Both FSMs SHALL be in their idle states.
REQ-025 Reset asserted mid-transaction SHALL abandon it; no response is issued after release.
REQ-026 The first transaction SHALL be accepted no earlier than the first rising edge after ARESETN deasserts.

Structure
REQ-027 Package servo_pkg SHALL hold:
- register offsets ADDR_CTRL/ADDR_PERIOD/ADDR_PULSE/ADDR_SCRATCH;
- the RESP_OKAY constant;
- enum types for the write and read FSM states.
REQ-028 The PWM counter and shadows SHALL be one sub-module, servo_pwm_gen (ports ACLK, ARESETN, enable, period, pulse, servo_pwm); the AXI logic stays in servo_axil_slave.

Verification
REQ-029 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read all four -> 0x1,0x2,0x3,0x4, every BRESP/RRESP=OKAY.
REQ-030 Write 0xAABBCCDD to 0xC with WSTRB=4'b1111, then 0x11223344 with WSTRB=4'b0101 -> readback 0xAA22CC44.
REQ-031 PERIOD=10, PULSE=3, CTRL=1 -> servo_pwm high 3 cycles, low 7 cycles, repeating. Write PULSE=5 mid-period -> the change appears only from the next period.
REQ-032 BREADY held low 20 cycles after a write -> BVALID stays high and AWREADY stays low. RREADY held low -> RDATA stable.
REQ-033 AWVALID for 5 cycles before WVALID -> no AWREADY until both are valid, then exactly one write commits.
REQ-034 Reset pulsed in W_RESP and in R_DATA -> BVALID/RVALID=0 immediately and all registers read 0 after release. PERIOD=0 with enable=1 -> servo_pwm stays 0.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared definitions for the AXI4-Lite servo PWM slave: register map,
// response code, FSM state types and the byte-strobe merge helper.
package servo_pkg;

    localparam logic [3:0] ADDR_CTRL    = 4'h0;
    localparam logic [3:0] ADDR_PERIOD  = 4'h4;
    localparam logic [3:0] ADDR_PULSE   = 4'h8;
    localparam logic [3:0] ADDR_SCRATCH = 4'hC;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_DATA = 2'd2
    } rstate_t;

    // Byte lane n takes the new data only where its strobe bit is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// PWM counter with period/pulse shadow registers that only reload at a
// period boundary (or while disabled), so mid-period writes never glitch.
module servo_pwm_gen #(
    parameter int WIDTH = 32
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             enable,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] pulse,
    output logic             servo_pwm
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period_act;
    logic [WIDTH-1:0] r_pulse_act;
    logic             r_pwm;
    logic             w_last;
    logic             w_idle;

    assign w_last = (r_cnt >= (r_period_act - WIDTH'(1)));
    // A zero period is treated as a permanent boundary so new settings still load.
    assign w_idle = !enable || (r_period_act == '0);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_cnt        <= '0;
            r_period_act <= '0;
            r_pulse_act  <= '0;
            r_pwm        <= 1'b0;
        end else if (w_idle) begin
            r_cnt        <= '0;
            r_period_act <= period;
            r_pulse_act  <= pulse;
            r_pwm        <= 1'b0;
        end else begin
            r_pwm <= (r_cnt < r_pulse_act);
            if (w_last) begin
                r_cnt        <= '0;
                r_period_act <= period;
                r_pulse_act  <= pulse;
            end else begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
        end
    end

    assign servo_pwm = r_pwm;

endmodule

// File: rtl/servo_axil_slave.sv
// AXI4-Lite slave exposing CTRL/PERIOD/PULSE/SCRATCH with independent
// write and read FSMs, driving a servo PWM generator.
module servo_axil_slave
    import servo_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic                            servo_pwm
);

    wstate_t     r_wstate;
    rstate_t     r_rstate;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [31:0] r_ctrl;
    logic [31:0] r_period;
    logic [31:0] r_pulse;
    logic [31:0] r_scratch;
    logic [1:0]  w_wsel;
    logic [1:0]  w_rsel;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_wsel   = AWADDR[3:2];
    assign w_rsel   = ARADDR[3:2];
    assign w_unused = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    // Write path: both address and data must be valid before anything is accepted.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_ctrl    <= '0;
            r_period  <= '0;
            r_pulse   <= '0;
            r_scratch <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (AWVALID && WVALID) begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_ACK;
                    end
                end
                W_ACK: begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b1;
                    r_wstate  <= W_RESP;
                    case (w_wsel)
                        ADDR_CTRL[3:2]:   r_ctrl    <= apply_wstrb(r_ctrl,    WDATA, WSTRB);
                        ADDR_PERIOD[3:2]: r_period  <= apply_wstrb(r_period,  WDATA, WSTRB);
                        ADDR_PULSE[3:2]:  r_pulse   <= apply_wstrb(r_pulse,   WDATA, WSTRB);
                        default:          r_scratch <= apply_wstrb(r_scratch, WDATA, WSTRB);
                    endcase
                end
                W_RESP: begin
                    if (BREADY) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                    r_wstate  <= W_IDLE;
                end
            endcase
        end
    end

    // Read mux sees pre-edge register values, so a same-edge write is not visible.
    always_comb begin
        w_rdata = '0;
        case (w_rsel)
            ADDR_CTRL[3:2]:   w_rdata = r_ctrl;
            ADDR_PERIOD[3:2]: w_rdata = r_period;
            ADDR_PULSE[3:2]:  w_rdata = r_pulse;
            default:          w_rdata = r_scratch;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (ARVALID) begin
                        r_arready <= 1'b1;
                        r_rstate  <= R_ACK;
                    end
                end
                R_ACK: begin
                    r_arready <= 1'b0;
                    r_rdata   <= w_rdata;
                    r_rvalid  <= 1'b1;
                    r_rstate  <= R_DATA;
                end
                R_DATA: begin
                    if (RREADY) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: begin
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                    r_rstate  <= R_IDLE;
                end
            endcase
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = RESP_OKAY;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = RESP_OKAY;

    servo_pwm_gen #(
        .WIDTH (32)
    ) u_pwm (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .enable    (r_ctrl[0]),
        .period    (r_period),
        .pulse     (r_pulse),
        .servo_pwm (servo_pwm)
    );

endmodule
